// File: rtl/mdu_sequencer.sv
// HI/LO multiply-divide sequencer: multi-cycle MULT/MULTU, optional DIV/DIVU, MTHI/MTLO/MFHI/MFLO.
// Define MDU_DIV_EN to build the restoring divider (DIV and FIX states); otherwise DIV/DIVU act as no-ops.
module mdu_sequencer #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ex_MduOp,
    input  logic [31:0] ex_busA,
    input  logic [31:0] ex_busB,
    output logic        MduBubble,
    output logic        mdu_busy,
    output logic [31:0] ex_HiLoOut,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        MUL
`ifdef MDU_DIV_EN
        ,
        DIV,
        FIX
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q;
    logic [31:0]        op_a_q, op_b_q;
    logic               mul_signed_q;
    logic               is_mul, op_valid, accept, mul_last;
    logic signed [63:0] mul_a, mul_b, product;

`ifdef MDU_DIV_EN
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_DIVU = 4'd4;

    logic [31:0] quot_q, rem_q;
    logic        q_neg_q, r_neg_q, div_zero_q;
    logic        is_div, div_signed;
    logic [32:0] rem_sh, diff;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign is_div     = (ex_MduOp == OP_DIV) || (ex_MduOp == OP_DIVU);
    assign div_signed = (ex_MduOp == OP_DIV);
    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_sh     = {rem_q, quot_q[31]};
    assign diff       = rem_sh - {1'b0, op_b_q};
`endif

    assign is_mul   = (ex_MduOp == OP_MULT) || (ex_MduOp == OP_MULTU);
`ifdef MDU_DIV_EN
    assign op_valid = is_mul || is_div || ((ex_MduOp >= OP_MFHI) && (ex_MduOp <= OP_MTLO));
`else
    assign op_valid = is_mul || ((ex_MduOp >= OP_MFHI) && (ex_MduOp <= OP_MTLO));
`endif
    assign mdu_busy  = (state_q != IDLE);
    assign MduBubble = op_valid & mdu_busy;
    assign accept    = op_valid & ~mdu_busy;
    assign mul_last  = (cnt_q == 5'(MUL_LAT - 1));

    // Sign- or zero-extend to 64 bits so one signed multiplier serves MULT and MULTU.
    assign mul_a   = {{32{mul_signed_q & op_a_q[31]}}, op_a_q};
    assign mul_b   = {{32{mul_signed_q & op_b_q[31]}}, op_b_q};
    assign product = mul_a * mul_b;

    always_comb begin
        ex_HiLoOut = 32'd0;
        if (!mdu_busy) begin
            if (ex_MduOp == OP_MFHI)      ex_HiLoOut = hi_q;
            else if (ex_MduOp == OP_MFLO) ex_HiLoOut = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) state_d = MUL;
`ifdef MDU_DIV_EN
                else if (accept && is_div) state_d = (ex_busB == 32'd0) ? FIX : DIV;
`endif
            end
            MUL: if (mul_last) state_d = IDLE;
`ifdef MDU_DIV_EN
            DIV: if (cnt_q == 5'd31) state_d = FIX;
            FIX: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            mul_signed_q <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
`ifdef MDU_DIV_EN
            quot_q       <= '0;
            rem_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            div_zero_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (accept) begin
                        if (is_mul) begin
                            op_a_q       <= ex_busA;
                            op_b_q       <= ex_busB;
                            mul_signed_q <= (ex_MduOp == OP_MULT);
                        end
`ifdef MDU_DIV_EN
                        else if (is_div) begin
                            op_a_q     <= ex_busA;
                            op_b_q     <= magnitude(ex_busB, div_signed);
                            quot_q     <= magnitude(ex_busA, div_signed);
                            rem_q      <= '0;
                            q_neg_q    <= div_signed & (ex_busA[31] ^ ex_busB[31]);
                            r_neg_q    <= div_signed & ex_busA[31];
                            div_zero_q <= (ex_busB == 32'd0);
                        end
`endif
                        else if (ex_MduOp == OP_MTHI) hi_q <= ex_busA;
                        else if (ex_MduOp == OP_MTLO) lo_q <= ex_busA;
                    end
                end
                MUL: begin
                    cnt_q <= mul_last ? 5'd0 : cnt_q + 5'd1;
                    if (mul_last) {hi_q, lo_q} <= product;
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    cnt_q <= (cnt_q == 5'd31) ? 5'd0 : cnt_q + 5'd1;
                    if (!diff[32]) begin
                        rem_q  <= diff[31:0];
                        quot_q <= {quot_q[30:0], 1'b1};
                    end else begin
                        rem_q  <= rem_sh[31:0];
                        quot_q <= {quot_q[30:0], 1'b0};
                    end
                end
                FIX: begin
                    if (div_zero_q) begin
                        hi_q <= op_a_q;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= apply_sign(rem_q, r_neg_q);
                        lo_q <= apply_sign(quot_q, q_neg_q);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
